// File: rtl/transfer_sender_if.sv
// Scanner-side and link-side signals of the serial byte sender.
// The master modport drives loads and peer ready; the slave is the sender.
interface transfer_sender_if #(
  parameter int COUNT_W = 3
);
  logic               loadByte;
  logic [7:0]         byteIn;
  logic               readyForTransferIn;
  logic               readyForTransferOut;
  logic               dataOut;
  logic               sending;
  logic [2:0]         byteCounter;
  logic [COUNT_W-1:0] bytesPending;
  logic               bufferFull;
  logic               overflow;

  modport master (
    output loadByte,
    output byteIn,
    output readyForTransferIn,
    input  readyForTransferOut,
    input  dataOut,
    input  sending,
    input  byteCounter,
    input  bytesPending,
    input  bufferFull,
    input  overflow
  );

  modport slave (
    input  loadByte,
    input  byteIn,
    input  readyForTransferIn,
    output readyForTransferOut,
    output dataOut,
    output sending,
    output byteCounter,
    output bytesPending,
    output bufferFull,
    output overflow
  );
endinterface

// File: rtl/transfer_sender.sv
// Serial link transmitter: byte FIFO feeding an MSB-first shifter.
// Bytes stream back-to-back while the peer stays ready at boundaries.
module transfer_sender #(
  parameter int DEPTH   = 4,
  parameter int COUNT_W = 3
) (
  input logic               clk,
  input logic               rst,
  transfer_sender_if.slave  bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    SEND    = 2'd2
  } state_t;

  state_t             state_q;
  logic [7:0]         mem_q [DEPTH];
  logic [PW-1:0]      head_q, tail_q;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [7:0]         shift_q;
  logic [2:0]         bitcnt_q;
  logic               rdy_q, send_q, ovf_q;
  logic               full, empty, pop, push;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    full  = (count_q == COUNT_W'(DEPTH));
    empty = (count_q == '0);
    // Pops only happen when the shifter is (re)loaded
    pop   = !empty && bus.readyForTransferIn &&
            ((state_q == REQUEST) ||
             (state_q == SEND && bitcnt_q == 3'd7));
    push  = bus.loadByte && (!full || pop);
    count_d = count_q + COUNT_W'(push) - COUNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= bus.byteIn;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      shift_q  <= '0;
      bitcnt_q <= '0;
      rdy_q    <= 1'b0;
      send_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push) tail_q <= nxt(tail_q);
      if (bus.loadByte && !push) ovf_q <= 1'b1;
      if (pop) begin
        head_q   <= nxt(head_q);
        shift_q  <= mem_q[head_q];
        bitcnt_q <= '0;
      end
      unique case (state_q)
        IDLE: begin
          if (!empty) begin
            state_q <= REQUEST;
            rdy_q   <= 1'b1;
          end
        end
        REQUEST: begin
          if (pop) begin
            state_q <= SEND;
            send_q  <= 1'b1;
          end
        end
        SEND: begin
          if (bitcnt_q == 3'd7) begin
            if (!pop) begin
              state_q <= IDLE;
              rdy_q   <= 1'b0;
              send_q  <= 1'b0;
            end
          end else begin
            shift_q  <= {shift_q[6:0], 1'b0};
            bitcnt_q <= bitcnt_q + 3'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          rdy_q   <= 1'b0;
          send_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.readyForTransferOut = rdy_q;
  assign bus.sending             = send_q;
  assign bus.dataOut             = send_q & shift_q[7];
  assign bus.byteCounter         = send_q ? bitcnt_q : 3'd0;
  assign bus.bytesPending        = count_q;
  assign bus.bufferFull          = full;
  assign bus.overflow            = ovf_q;
endmodule

// File: tb/tb_transfer_sender.sv
// Directed bench for transfer_sender.
// Expected bit streams and counts are hand-derived.
module tb_transfer_sender;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  transfer_sender_if #(.COUNT_W(3)) bus();

  transfer_sender #(.DEPTH(4), .COUNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] b);
    bus.loadByte = 1'b1;
    bus.byteIn   = b;
    tick();
    bus.loadByte = 1'b0;
    bus.byteIn   = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
    tick();
  endtask

  task automatic send_bits(input string tag,
                           input logic [31:0] d,
                           input int nb);
    for (int i = 0; i < nb; i++) begin
      chk({tag, "_bit"}, 32'(bus.dataOut), 32'(d[nb-1-i]));
      chk({tag, "_cnt"}, 32'(bus.byteCounter), 32'(i % 8));
      chk({tag, "_snd"}, 32'(bus.sending), 32'd1);
      tick();
    end
  endtask

  initial begin
    int saw;
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b0;
    bus.loadByte           = 1'b0;
    bus.byteIn             = 8'h00;
    bus.readyForTransferIn = 1'b0;

    // Test 1: reset state and single byte 0xA5
    do_reset();
    chk("rst_rdy", 32'(bus.readyForTransferOut), 0);
    chk("rst_snd", 32'(bus.sending), 0);
    chk("rst_dat", 32'(bus.dataOut), 0);
    chk("rst_cnt", 32'(bus.byteCounter), 0);
    chk("rst_pend", 32'(bus.bytesPending), 0);
    chk("rst_full", 32'(bus.bufferFull), 0);
    chk("rst_ovf", 32'(bus.overflow), 0);
    bus.readyForTransferIn = 1'b1;
    load(8'hA5);
    chk("t1_rdy1", 32'(bus.readyForTransferOut), 0);
    chk("t1_pend1", 32'(bus.bytesPending), 1);
    tick();
    chk("t1_rdy2", 32'(bus.readyForTransferOut), 1);
    chk("t1_snd2", 32'(bus.sending), 0);
    tick();
    send_bits("t1", 32'hA5, 8);
    chk("t1_end_snd", 32'(bus.sending), 0);
    chk("t1_end_rdy", 32'(bus.readyForTransferOut), 0);
    chk("t1_end_pend", 32'(bus.bytesPending), 0);

    // Test 2: back-to-back 0x3C, 0xFF
    load(8'h3C);
    load(8'hFF);
    chk("t2_rdy", 32'(bus.readyForTransferOut), 1);
    chk("t2_pend2", 32'(bus.bytesPending), 2);
    tick();
    chk("t2_pend1", 32'(bus.bytesPending), 1);
    send_bits("t2a", 32'h3C, 8);
    chk("t2_pend0", 32'(bus.bytesPending), 0);
    send_bits("t2b", 32'hFF, 8);
    chk("t2_end_snd", 32'(bus.sending), 0);

    // Test 3: peer not ready holds REQUEST
    bus.readyForTransferIn = 1'b0;
    load(8'h81);
    tick();
    repeat (10) tick();
    chk("t3_rdy", 32'(bus.readyForTransferOut), 1);
    chk("t3_snd", 32'(bus.sending), 0);
    chk("t3_dat", 32'(bus.dataOut), 0);
    chk("t3_pend", 32'(bus.bytesPending), 1);
    bus.readyForTransferIn = 1'b1;
    tick();
    send_bits("t3", 32'h81, 8);
    chk("t3_end_snd", 32'(bus.sending), 0);

    // Test 4: overflow with DEPTH 4
    do_reset();
    bus.readyForTransferIn = 1'b0;
    for (int i = 1; i <= 5; i++) load(8'(i));
    chk("t4_full", 32'(bus.bufferFull), 1);
    chk("t4_ovf", 32'(bus.overflow), 1);
    chk("t4_pend", 32'(bus.bytesPending), 4);
    bus.readyForTransferIn = 1'b1;
    tick();
    chk("t4_pend3", 32'(bus.bytesPending), 3);
    send_bits("t4", 32'h01020304, 32);
    chk("t4_end_snd", 32'(bus.sending), 0);
    chk("t4_end_pend", 32'(bus.bytesPending), 0);
    saw = 0;
    repeat (6) begin
      tick();
      if (bus.sending) saw = 1;
    end
    chk("t4_no_05", 32'(saw), 0);

    // Test 5: load accepted on the pop edge while full
    do_reset();
    bus.readyForTransferIn = 1'b1;
    load(8'h11);
    tick();
    tick();
    load(8'h81);
    load(8'h42);
    load(8'h24);
    load(8'h18);
    tick();
    tick();
    tick();
    chk("t5_cnt7", 32'(bus.byteCounter), 7);
    chk("t5_full", 32'(bus.bufferFull), 1);
    load(8'h55);
    chk("t5_pend", 32'(bus.bytesPending), 4);
    chk("t5_ovf", 32'(bus.overflow), 0);
    chk("t5_snd", 32'(bus.sending), 1);
    chk("t5_cnt0", 32'(bus.byteCounter), 0);
    chk("t5_dat", 32'(bus.dataOut), 1);

    // Test 6: async reset mid-byte
    do_reset();
    load(8'hF0);
    tick();
    tick();
    tick();
    tick();
    tick();
    chk("t6_cnt3", 32'(bus.byteCounter), 3);
    chk("t6_snd", 32'(bus.sending), 1);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_rst_snd", 32'(bus.sending), 0);
    chk("t6_rst_rdy", 32'(bus.readyForTransferOut), 0);
    chk("t6_rst_cnt", 32'(bus.byteCounter), 0);
    chk("t6_rst_pend", 32'(bus.bytesPending), 0);
    #2;
    rst = 1'b1;
    saw = 0;
    repeat (12) begin
      tick();
      if (bus.sending || bus.readyForTransferOut) saw = 1;
    end
    chk("t6_quiet", 32'(saw), 0);
    chk("t6_pend", 32'(bus.bytesPending), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/transfer_sender.md
Name: transfer_sender

Overview:
- Transmit end of the serial byte-transfer link: buffers parallel bytes from the local scanner and serializes them MSB-first onto the single-bit data line.
- Handshakes with the receiving transfer center through a ready pair.
- Sits between the local scanner output and the inter-node serial link.

Parameters:
- DEPTH, 4, byte buffer entries (2..7)
- COUNT_W, 3, width of bytesPending (must hold DEPTH)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- loadByte  input  1  write byteIn into the buffer this cycle
- byteIn  input  8  parallel byte from the local scanner
- readyForTransferIn  input  1  peer receiver ready to accept bits
- readyForTransferOut  output  1  sender requesting or performing a transfer
- dataOut  output  1  serial data line, MSB first
- sending  output  1  high while a bit of a valid byte is on dataOut
- byteCounter  output  3  index of the bit currently on dataOut (0 = bit7)
- bytesPending  output  COUNT_W  bytes held in the buffer, excluding the byte being shifted
- bufferFull  output  1  bytesPending == DEPTH
- overflow  output  1  sticky; a load was dropped

Behaviour:
- Reset (rst low, async): state IDLE; buffer empty; all outputs 0; shift register 0. Any byte in flight is aborted and not resent.
- Buffer: circular FIFO, DEPTH x 8, with wrapping head/tail pointers.
  - Load when not full: accepted.
  - Load when full: dropped and overflow set, unless a pop occurs on the same edge; then the load is accepted and the count is unchanged.
  - A pop occurs only when SEND loads the shift register.
- State machine (registered):
  - IDLE: readyForTransferOut=0, sending=0, dataOut=0. bytesPending>0 -> REQUEST on the next edge.
  - REQUEST: readyForTransferOut=1. At an edge where readyForTransferIn=1 -> SEND; the head byte is popped into the shift register, byteCounter=0, dataOut=bit7. Otherwise the block waits indefinitely.
  - SEND: readyForTransferOut=1, sending=1, dataOut=shift[7].
    - Each edge: shift left and byteCounter+1.
    - At the edge where byteCounter==7: if bytesPending>0 and readyForTransferIn=1, pop the next byte with byteCounter=0. This is back-to-back with no gap bit. Otherwise -> IDLE.
- Latency:
  - A load into an empty buffer in IDLE gives readyForTransferOut=1 two edges later.
  - The first bit appears on the edge after readyForTransferIn is sampled high in REQUEST.
  - One byte occupies exactly 8 cycles.
- Mid-byte readyForTransferIn deassertion: ignored; the byte completes. The signal is only sampled at entry and at byte boundaries.
- Loads are accepted in every state, including during SEND.
- After the last byte, IDLE lasts at least one cycle before a new REQUEST, which gives the receiver a frame boundary.
- All outputs are registered or decoded directly from registers; no combinational path from inputs to outputs.
- overflow clears only on reset.

Test Plan:
1. Reset, load 0xA5, hold readyForTransferIn=1 -> readyForTransferOut rises 2 edges after the load. dataOut over 8 cycles is 1,0,1,0,0,1,0,1 with byteCounter 0..7. The block then returns to IDLE with sending=0 and bytesPending=0.
2. Load 0x3C then 0xFF, peer ready -> 16 contiguous bits 00111100 11111111, sending held high throughout, no gap cycle, bytesPending 2->1->0.
3. Load 0x81 with readyForTransferIn=0 for 10 cycles -> stays in REQUEST with dataOut=0 and bytesPending=1. Raise ready -> 10000001 is sent.
4. Five loads (0x01..0x05) with peer not ready and DEPTH=4 -> bufferFull=1, overflow=1. Raise ready -> 0x01..0x04 are sent; 0x05 is never sent.
5. Buffer full in SEND, loadByte on the byte-boundary pop edge -> the load is accepted, overflow stays 0, bytesPending stays 4.
6. Pull rst low at byteCounter==3 of 0xF0 -> all outputs 0 immediately without waiting for a clock. After release: IDLE, bytesPending=0, nothing is transmitted.
